// File: rtl/axi_write_pkg.sv
// Shared constants, FSM state type and byte-lane helper for the AXI3 write master.
package axi_write_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } state_t;

    // Byte-lane enables for a 32-bit bus from transfer size and low address bits.
    function automatic logic [3:0] wstrb_of(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            3'd0:    s = 4'b0001 << a;
            3'd1:    s = 4'b0011 << {a[1], 1'b0};
            default: s = 4'hF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/write_master_if.sv
// AW/W/B channel bundle between write_master and write_slave.
interface write_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic [1:0]          AWLOCK;
    logic [3:0]          AWCACHE;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;

    logic [ID_W-1:0]     WID;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/write_beat_fifo.sv
// Beat buffer: DEPTH entries of {data, addr[1:0]}, with a one-entry lookahead port.
module write_beat_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [WIDTH-1:0]             o_next,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    // Entry behind the head; pointer wraps naturally because DEPTH is a power of two.
    assign o_next  = r_mem[r_rd + 1'b1];

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/write_master.sv
// AXI3 write master: buffers device beats and issues one AW/W/B burst at a time.
module write_master
    import axi_write_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int MASTER_ID = 0,
    parameter int DEPTH     = 16
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [DATA_W-1:0]  datawrite,
    input  logic [ADDR_W-1:0]  addresswrite,
    input  logic               memoryWrite,
    input  logic               devclock,
    input  logic [ADDR_W-1:0]  WADDR,
    input  logic [3:0]         WLEN,
    input  logic [2:0]         WSIZE,
    input  logic [1:0]         WBURST,
    input  logic [1:0]         WLOCK,
    input  logic [3:0]         WCACHE,
    input  logic [2:0]         WPROT,
    write_master_if.master     axi,
    output logic [1:0]         response
);
    localparam int BEAT_W = DATA_W + 2;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int STRB_W = DATA_W / 8;

    state_t            r_state;
    logic [3:0]        r_beat;
    logic [BEAT_W-1:0] w_head;
    logic [BEAT_W-1:0] w_next;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_need;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_start;
    logic              w_unused;

    assign w_push   = memoryWrite & devclock;
    assign w_pop    = axi.WVALID & axi.WREADY;
    assign w_need   = CNT_W'(WLEN) + CNT_W'(1);
    assign w_start  = (w_count >= w_need);
    assign axi.WID  = ID_W'(MASTER_ID);
    assign w_unused = &{1'b0, addresswrite[ADDR_W-1:2], w_full, w_empty};

    write_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (ACLK),
        .i_rst   (ARESETn),
        .i_push  (w_push),
        .i_data  ({datawrite, addresswrite[1:0]}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Burst sequencer with registered channel outputs.
    // WDATA/WSTRB are loaded one beat ahead: the head at AW handshake, then the
    // lookahead entry on each W handshake, so the registered beat tracks the pop.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            axi.AWID    <= '0;
            axi.AWADDR  <= '0;
            axi.AWLEN   <= '0;
            axi.AWSIZE  <= '0;
            axi.AWBURST <= '0;
            axi.AWLOCK  <= '0;
            axi.AWCACHE <= '0;
            axi.AWPROT  <= '0;
            axi.AWVALID <= 1'b0;
            axi.WDATA   <= '0;
            axi.WSTRB   <= '0;
            axi.WLAST   <= 1'b0;
            axi.WVALID  <= 1'b0;
            axi.BREADY  <= 1'b0;
            response    <= RESP_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        axi.AWID    <= ID_W'(MASTER_ID);
                        axi.AWADDR  <= WADDR;
                        axi.AWLEN   <= WLEN;
                        axi.AWSIZE  <= WSIZE;
                        axi.AWBURST <= WBURST;
                        axi.AWLOCK  <= WLOCK;
                        axi.AWCACHE <= WCACHE;
                        axi.AWPROT  <= WPROT;
                        axi.AWVALID <= 1'b1;
                        r_state     <= AW;
                    end
                end
                AW: begin
                    if (axi.AWREADY) begin
                        axi.AWVALID <= 1'b0;
                        axi.WVALID  <= 1'b1;
                        axi.WDATA   <= w_head[BEAT_W-1:2];
                        axi.WSTRB   <= STRB_W'(wstrb_of(axi.AWSIZE, w_head[1:0]));
                        axi.WLAST   <= (axi.AWLEN == 4'd0);
                        r_beat      <= '0;
                        r_state     <= W;
                    end
                end
                W: begin
                    if (axi.WREADY) begin
                        if (axi.WLAST) begin
                            axi.WVALID <= 1'b0;
                            axi.WLAST  <= 1'b0;
                            axi.BREADY <= 1'b1;
                            r_state    <= B;
                        end else begin
                            axi.WDATA <= w_next[BEAT_W-1:2];
                            axi.WSTRB <= STRB_W'(wstrb_of(axi.AWSIZE, w_next[1:0]));
                            axi.WLAST <= ((r_beat + 4'd1) == axi.AWLEN);
                            r_beat    <= r_beat + 4'd1;
                        end
                    end
                end
                B: begin
                    if (axi.BVALID) begin
                        response   <= (axi.BID != ID_W'(MASTER_ID)) ? RESP_SLVERR : axi.BRESP;
                        axi.BREADY <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_master.sv
// Directed/randomized bench for write_master with a queue-based buffer model.
module tb_write_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] datawrite;
    logic [31:0] addresswrite;
    logic        memoryWrite;
    logic        devclock;
    logic [31:0] WADDR;
    logic [3:0]  WLEN;
    logic [2:0]  WSIZE;
    logic [1:0]  WBURST;
    logic [1:0]  WLOCK;
    logic [3:0]  WCACHE;
    logic [2:0]  WPROT;
    logic [1:0]  response;

    write_master_if ax ();

    write_master dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .datawrite    (datawrite),
        .addresswrite (addresswrite),
        .memoryWrite  (memoryWrite),
        .devclock     (devclock),
        .WADDR        (WADDR),
        .WLEN         (WLEN),
        .WSIZE        (WSIZE),
        .WBURST       (WBURST),
        .WLOCK        (WLOCK),
        .WCACHE       (WCACHE),
        .WPROT        (WPROT),
        .axi          (ax),
        .response     (response)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  a;
    } beat_t;

    beat_t       q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] e_addr;
    logic [3:0]  e_len;
    logic [2:0]  e_size;
    logic [1:0]  e_burst;
    logic [1:0]  e_lock;
    logic [3:0]  e_cache;
    logic [2:0]  e_prot;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_strb(input int size, input int a);
        if (size == 0) return 4'(1 << a);
        if (size == 1) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [63:0] aw_obs();
        return 64'({ax.AWADDR, ax.AWLEN, ax.AWSIZE, ax.AWBURST, ax.AWLOCK, ax.AWCACHE, ax.AWPROT});
    endfunction

    function automatic logic [63:0] aw_exp();
        return 64'({e_addr, e_len, e_size, e_burst, e_lock, e_cache, e_prot});
    endfunction

    // One clock; the model mirrors a buffer of 16 that drops pushes when full.
    task automatic cyc(input bit pop);
        bit    acc;
        beat_t b;
        acc = memoryWrite && devclock && (q.size() < 16);
        b.d = datawrite;
        b.a = addresswrite[1:0];
        @(posedge ACLK);
        #1;
        if (pop && q.size() != 0) q.delete(0);
        if (acc) q.push_back(b);
        if (memoryWrite) begin
            datawrite    = $urandom;
            addresswrite = $urandom;
        end
    endtask

    task automatic set_attr(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        e_addr  = addr;  WADDR  = addr;
        e_len   = len;   WLEN   = len;
        e_size  = size;  WSIZE  = size;
        e_burst = burst; WBURST = burst;
        e_lock  = 2'($urandom);  WLOCK  = e_lock;
        e_cache = 4'($urandom);  WCACHE = e_cache;
        e_prot  = 3'($urandom);  WPROT  = e_prot;
    endtask

    task automatic push_one(input logic [31:0] d, input logic [31:0] a);
        memoryWrite  = 1'b1;
        devclock     = 1'b1;
        datawrite    = d;
        addresswrite = a;
        cyc(0);
        memoryWrite  = 1'b0;
        devclock     = 1'b0;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_one($urandom, $urandom);
    endtask

    task automatic burst(input int aw_delay, input int w_stall, input bit push_during,
                         input logic [1:0] bresp, input logic [3:0] bid);
        int n;
        n = 0;
        while (ax.AWVALID !== 1'b1 && n < 40) begin
            cyc(0);
            n++;
        end
        chk("awvalid_rise", 64'(ax.AWVALID), 64'd1);
        if (ax.AWVALID !== 1'b1) return;
        chk("aw_attrs", aw_obs(), aw_exp());
        chk("awid", 64'(ax.AWID), 64'd0);
        chk("no_w_before_aw", 64'(ax.WVALID), 64'd0);
        for (int i = 0; i < aw_delay; i++) begin
            cyc(0);
            chk("aw_hold", 64'({ax.AWVALID, ax.WVALID}), 64'b10);
            chk("aw_stable", aw_obs(), aw_exp());
        end
        ax.AWREADY = 1'b1;
        cyc(0);
        ax.AWREADY = 1'b0;
        chk("aw_done_w_start", 64'({ax.AWVALID, ax.WVALID}), 64'b01);
        for (int i = 0; i <= int'(e_len); i++) begin
            if (q.size() == 0) begin
                chk("model_has_beat", 64'(q.size()), 64'd1);
                return;
            end
            if (push_during) begin
                memoryWrite = 1'b1;
                devclock    = 1'b1;
            end
            for (int s = 0; s < w_stall; s++) begin
                chk("w_stall_hold", 64'({ax.WVALID, ax.WDATA}), 64'({1'b1, q[0].d}));
                cyc(0);
            end
            ax.WREADY = 1'b1;
            chk("wvalid", 64'(ax.WVALID), 64'd1);
            chk("wdata", 64'(ax.WDATA), 64'(q[0].d));
            chk("wstrb", 64'(ax.WSTRB), 64'(exp_strb(int'(e_size), int'(q[0].a))));
            chk("wlast", 64'(ax.WLAST), 64'(i == int'(e_len)));
            chk("wid", 64'(ax.WID), 64'd0);
            cyc(1);
            ax.WREADY = 1'b0;
        end
        memoryWrite = 1'b0;
        devclock    = 1'b0;
        chk("b_phase", 64'({ax.WVALID, ax.BREADY}), 64'b01);
        ax.BVALID = 1'b1;
        ax.BRESP  = bresp;
        ax.BID    = bid;
        cyc(0);
        ax.BVALID = 1'b0;
        chk("bready_drop", 64'(ax.BREADY), 64'd0);
        chk("response", 64'(response), (bid != 4'd0) ? 64'd2 : 64'(bresp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn      = 1'b1;
        memoryWrite  = 1'b0;
        devclock     = 1'b0;
        datawrite    = '0;
        addresswrite = '0;
        ax.AWREADY   = 1'b0;
        ax.WREADY    = 1'b0;
        ax.BVALID    = 1'b0;
        ax.BRESP     = 2'b00;
        ax.BID       = 4'd0;
        set_attr(32'h0, 4'd0, 3'd2, 2'b01);
        cyc(0);
        cyc(0);
        chk("rst_valids", 64'({ax.AWVALID, ax.WVALID, ax.WLAST, ax.BREADY}), 64'd0);
        chk("rst_aw", aw_obs(), 64'd0);
        chk("rst_awid", 64'(ax.AWID), 64'd0);
        chk("rst_wdata_wstrb", 64'({ax.WDATA, ax.WSTRB}), 64'd0);
        chk("rst_response", 64'(response), 64'd0);
        ARESETn = 1'b0;
        cyc(0);

        // Single beat
        set_attr(32'h1000_0040, 4'd0, 3'd2, 2'b01);
        push_one(32'hDEADBEEF, 32'h0);
        burst(0, 0, 0, 2'b00, 4'd0);

        // 4-beat INCR with W stalls
        set_attr(32'h2000_0000, 4'd3, 3'd2, 2'b01);
        for (int i = 1; i <= 4; i++) push_one(32'(i), 32'h0);
        burst(0, 2, 0, 2'b00, 4'd0);

        // AW backpressure
        set_attr($urandom, 4'd2, 3'd2, 2'b01);
        push_rand(3);
        burst(5, 0, 0, 2'b00, 4'd0);

        // Byte write at lane 2, then random halfword lanes
        set_attr(32'h3000_0002, 4'd0, 3'd0, 2'b00);
        push_one($urandom, 32'h1234_5672);
        burst(0, 0, 0, 2'b00, 4'd0);
        set_attr($urandom, 4'd3, 3'd1, 2'b01);
        push_rand(4);
        burst(0, 1, 0, 2'b00, 4'd0);

        // Error response, then a clean burst
        set_attr($urandom, 4'd1, 3'd2, 2'b01);
        push_rand(2);
        burst(1, 0, 0, 2'b10, 4'd0);
        set_attr($urandom, 4'd0, 3'd0, 2'b01);
        push_rand(1);
        burst(0, 0, 0, 2'b00, 4'd0);

        // Foreign BID is consumed and reported as SLVERR
        set_attr($urandom, 4'd0, 3'd2, 2'b01);
        push_rand(1);
        burst(0, 0, 0, 2'b00, 4'd3);

        // devclock qualifies pushes
        set_attr($urandom, 4'd0, 3'd2, 2'b01);
        memoryWrite = 1'b1;
        devclock    = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0);
        memoryWrite = 1'b0;
        devclock    = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0);
        devclock    = 1'b0;
        chk("no_push_gated", 64'(ax.AWVALID), 64'd0);

        // Leftover beats start a second burst with the same attributes
        set_attr($urandom, 4'd2, 3'($urandom_range(0, 2)), 2'b01);
        push_rand(6);
        burst(0, 0, 0, 2'b00, 4'd0);
        burst(0, 0, 0, 2'b00, 4'd0);

        // Pushes during W overlap pops; remaining beats drain in a second burst
        set_attr($urandom, 4'd3, 3'd2, 2'b01);
        push_rand(4);
        burst(0, 0, 1, 2'b00, 4'd0);
        burst(0, 0, 0, 2'b00, 4'd0);

        // Full buffer: pushes 17 and 18 are dropped
        set_attr($urandom, 4'd15, 3'd2, 2'b01);
        push_rand(18);
        chk("model_full", 64'(q.size()), 64'd16);
        burst(0, 0, 0, 2'b01, 4'd0);

        // Reset while AWVALID is up discards the burst and the buffer
        set_attr($urandom, 4'd0, 3'd2, 2'b01);
        push_rand(2);
        cyc(0);
        chk("pre_reset_awvalid", 64'(ax.AWVALID), 64'd1);
        ARESETn = 1'b1;
        cyc(0);
        ARESETn = 1'b0;
        q.delete();
        chk("reset_abort", 64'({ax.AWVALID, ax.WVALID, ax.BREADY}), 64'd0);
        for (int i = 0; i < 4; i++) cyc(0);
        chk("buffer_discarded", 64'(ax.AWVALID), 64'd0);
        push_rand(1);
        burst(0, 0, 0, 2'b00, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
